// File: rtl/immgen_pipe.sv
// immgen_pipe: decode-stage immediate generator with a registered
// valid/ready output stage backed by a 2-entry skid buffer.
//
// Extracts and sign-extends the immediate of each instruction, classifies
// its format, flags unsupported encodings and precomputes pc + imm.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_flush                 synchronous flush, drops everything in flight
//   i_valid/o_ready         upstream handshake (o_ready is a flop)
//   i_inst, i_pc            instruction and its pc
//   o_valid/i_ready         downstream handshake
//   o_imm, o_imm_type       extended immediate, format code (0 NONE .. 6 Z)
//   o_illegal               unsupported encoding
//   o_pc, o_target          pc passed through, pc + imm
//
// state   | meaning
// --------+-------------------------------------------
// S_EMPTY | output register invalid, skid invalid
// S_ONE   | output register valid, skid invalid
// S_FULL  | output and skid registers both valid
module immgen_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter bit          EN_ZIMM = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_imm_type,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_target
);

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;
    localparam logic [2:0] TYPE_Z    = 3'd6;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            illegal;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } beat_t;

    logic [4:0]  opcode;
    logic [31:0] imm32;
    logic [2:0]  dec_typ;
    logic        dec_illegal;
    beat_t       dec_beat;

    state_e state_q, state_d;
    logic   ready_q;
    beat_t  out_q, skid_q, out_d;
    logic   load_out, load_skid, out_from_skid;
    logic   accept, consume;

    assign opcode = i_inst[6:2];

    always_comb begin
        imm32       = '0;
        dec_typ     = TYPE_NONE;
        dec_illegal = 1'b0;
        if (i_inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                5'b00100, 5'b00000, 5'b11001: begin
                    dec_typ = TYPE_I;
                    imm32   = {{20{i_inst[31]}}, i_inst[31:20]};
                end
                5'b01000: begin
                    dec_typ = TYPE_S;
                    imm32   = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                end
                5'b11000: begin
                    dec_typ = TYPE_B;
                    imm32   = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                               i_inst[30:25], i_inst[11:8], 1'b0};
                end
                5'b01101, 5'b00101: begin
                    dec_typ = TYPE_U;
                    imm32   = {i_inst[31:12], 12'b0};
                end
                5'b11011: begin
                    dec_typ = TYPE_J;
                    imm32   = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                               i_inst[20], i_inst[30:21], 1'b0};
                end
                5'b11100: begin
                    if (EN_ZIMM && i_inst[14]) begin
                        dec_typ = TYPE_Z;
                        imm32   = {27'b0, i_inst[19:15]};
                    end
                end
                5'b01100, 5'b00011: begin
                    dec_typ = TYPE_NONE;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // All formats are built as 32-bit values with the correct top bit
    // (zimm has bit 31 clear), so one signed widen covers XLEN=64.
    always_comb begin
        dec_beat.imm     = XLEN'($signed(imm32));
        dec_beat.typ     = dec_typ;
        dec_beat.illegal = dec_illegal;
        dec_beat.pc      = i_pc;
        dec_beat.target  = i_pc + XLEN'($signed(imm32));
    end

    assign accept  = i_valid & ready_q;
    assign consume = (state_q != S_EMPTY) & i_ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d  = S_ONE;
                    load_out = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = S_FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // ready_q is low here, so no new beat can arrive
                if (consume) begin
                    state_d       = S_ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
        if (i_flush) begin
            state_d   = S_EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
        end
    end

    assign out_d = out_from_skid ? skid_q : dec_beat;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_EMPTY;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != S_FULL);
            if (load_out) begin
                out_q <= out_d;
            end
            if (load_skid) begin
                skid_q <= dec_beat;
            end
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = (state_q != S_EMPTY);
    assign o_imm      = out_q.imm;
    assign o_imm_type = out_q.typ;
    assign o_illegal  = out_q.illegal;
    assign o_pc       = out_q.pc;
    assign o_target   = out_q.target;

endmodule

// File: tb/tb_immgen_pipe.sv
module tb_immgen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [63:0] pc;
        logic [63:0] tgt;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_inst = '0;
    logic [63:0] pc64 = '0;

    logic        o_ready32, o_valid32, o_ill32;
    logic [2:0]  o_typ32;
    logic [31:0] o_imm32, o_pc32, o_tgt32;
    logic        o_ready64, o_valid64, o_ill64;
    logic [2:0]  o_typ64;
    logic [63:0] o_imm64, o_pc64, o_tgt64;

    exp_t q32[$];
    exp_t q64[$];
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    immgen_pipe #(.XLEN(32), .EN_ZIMM(1'b1)) dut32 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready32),
        .i_inst(i_inst), .i_pc(pc64[31:0]),
        .o_valid(o_valid32), .i_ready(i_ready),
        .o_imm(o_imm32), .o_imm_type(o_typ32), .o_illegal(o_ill32),
        .o_pc(o_pc32), .o_target(o_tgt32)
    );

    immgen_pipe #(.XLEN(64), .EN_ZIMM(1'b0)) dut64 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready64),
        .i_inst(i_inst), .i_pc(pc64),
        .o_valid(o_valid64), .i_ready(i_ready),
        .o_imm(o_imm64), .o_imm_type(o_typ64), .o_illegal(o_ill64),
        .o_pc(o_pc64), .o_target(o_tgt64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] typ,
                                input logic ill, input logic [63:0] pc, input logic [63:0] tgt);
        exp_t e;
        e.imm = imm; e.typ = typ; e.ill = ill; e.pc = pc; e.tgt = tgt;
        return e;
    endfunction

    // Reference decode: immediates assembled by signed arithmetic on fields.
    function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc,
                                   input bit x64, input bit zimm);
        exp_t       e;
        int signed  si;
        longint     s;
        si = $signed(inst);
        s  = 0;
        e  = '0;
        if (inst[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (inst[6:2])
                5'b00100, 5'b00000, 5'b11001: begin
                    e.typ = 3'd1; s = longint'(si >>> 20);
                end
                5'b01000: begin
                    e.typ = 3'd2;
                    s = longint'(si >>> 25) * 32 + longint'(inst[11:7]);
                end
                5'b11000: begin
                    e.typ = 3'd3;
                    s = longint'(si >>> 31) * 4096 + longint'(inst[7]) * 2048
                      + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                end
                5'b01101, 5'b00101: begin
                    e.typ = 3'd4; s = longint'(si >>> 12) * 4096;
                end
                5'b11011: begin
                    e.typ = 3'd5;
                    s = longint'(si >>> 31) * 1048576 + longint'(inst[19:12]) * 4096
                      + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                end
                5'b11100: begin
                    if (zimm && inst[14]) begin
                        e.typ = 3'd6; s = longint'(inst[19:15]);
                    end
                end
                5'b01100, 5'b00011: e.typ = 3'd0;
                default: e.ill = 1'b1;
            endcase
        end
        e.imm = s;
        e.pc  = pc;
        e.tgt = pc + e.imm;
        if (!x64) begin
            e.imm = {32'b0, e.imm[31:0]};
            e.pc  = {32'b0, e.pc[31:0]};
            e.tgt = {32'b0, e.tgt[31:0]};
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [4:0]  op;
        r = $urandom;
        case ($urandom_range(0, 13))
            0: op = 5'b00100;  1: op = 5'b00000;  2: op = 5'b11001;
            3: op = 5'b01000;  4: op = 5'b11000;  5: op = 5'b01101;
            6: op = 5'b00101;  7: op = 5'b11011;  8: op = 5'b11100;
            9: op = 5'b01100; 10: op = 5'b00011;
            default: op = 5'($urandom);
        endcase
        r[6:2] = op;
        if ($urandom_range(0, 9) != 0) r[1:0] = 2'b11;
        return r;
    endfunction

    // Called at posedge+1; the queue size then equals buffer occupancy.
    task automatic issue(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                         input bit rdy, input bit fl, input exp_t e32, input exp_t e64);
        bit acc;
        i_valid = v; i_inst = inst; pc64 = pc; i_ready = rdy; i_flush = fl;
        acc = v && !fl && (q32.size() < 2);
        @(posedge i_clk); #1;
        if (fl) begin
            q32.delete();
            q64.delete();
        end
        if (acc) begin
            q32.push_back(e32);
            q64.push_back(e64);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                        input bit rdy, input bit fl);
        issue(v, inst, pc, rdy, fl, model(inst, pc, 1'b0, 1'b1), model(inst, pc, 1'b1, 1'b0));
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        @(posedge i_clk); #1;
        q32.delete(); q64.delete();
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        chk("rst_valid32", o_valid32, 0);  chk("rst_ready32", o_ready32, 1);
        chk("rst_imm32", o_imm32, 0);      chk("rst_type32", o_typ32, 0);
        chk("rst_ill32", o_ill32, 0);      chk("rst_pc32", o_pc32, 0);
        chk("rst_tgt32", o_tgt32, 0);
        chk("rst_valid64", o_valid64, 0);  chk("rst_ready64", o_ready64, 1);
        chk("rst_imm64", o_imm64, 0);      chk("rst_type64", o_typ64, 0);
        chk("rst_ill64", o_ill64, 0);      chk("rst_pc64", o_pc64, 0);
        chk("rst_tgt64", o_tgt64, 0);
    endtask

    // Monitor: handshake checked against scoreboard occupancy, beats popped
    // and compared on each consume.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset) begin
            chk("valid32", o_valid32, q32.size() != 0);
            chk("ready32", o_ready32, q32.size() < 2);
            chk("valid64", o_valid64, q64.size() != 0);
            chk("ready64", o_ready64, q64.size() < 2);
            if (!i_flush && i_ready && q32.size() != 0) begin
                e = q32.pop_front();
                chk("imm32", {32'b0, o_imm32}, e.imm);
                chk("type32", o_typ32, e.typ);
                chk("ill32", o_ill32, e.ill);
                chk("pc32", {32'b0, o_pc32}, e.pc);
                chk("tgt32", {32'b0, o_tgt32}, e.tgt);
            end
            if (!i_flush && i_ready && q64.size() != 0) begin
                e = q64.pop_front();
                chk("imm64", o_imm64, e.imm);
                chk("type64", o_typ64, e.typ);
                chk("ill64", o_ill64, e.ill);
                chk("pc64", o_pc64, e.pc);
                chk("tgt64", o_tgt64, e.tgt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b, c;
        do_reset();

        // Directed vectors with hand-derived expectations.
        issue(1, 32'hFFF00093, 64'h0, 1, 0,
              mk(64'hFFFFFFFF, 3'd1, 0, 64'h0, 64'hFFFFFFFF),
              mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 0, 64'h0, 64'hFFFFFFFFFFFFFFFF));
        issue(1, 32'hFE000EE3, 64'h100, 1, 0,
              mk(64'hFFFFFFFC, 3'd3, 0, 64'h100, 64'hFC),
              mk(64'hFFFFFFFFFFFFFFFC, 3'd3, 0, 64'h100, 64'hFC));
        issue(1, 32'h800000B7, 64'h10, 1, 0,
              mk(64'h80000000, 3'd4, 0, 64'h10, 64'h80000010),
              mk(64'hFFFFFFFF80000000, 3'd4, 0, 64'h10, 64'hFFFFFFFF80000010));
        issue(1, 32'h300FD073, 64'h20, 1, 0,
              mk(64'h1F, 3'd6, 0, 64'h20, 64'h3F),
              mk(64'h0, 3'd0, 0, 64'h20, 64'h20));
        issue(1, 32'h00000000, 64'h40, 1, 0,
              mk(64'h0, 3'd0, 1, 64'h40, 64'h40),
              mk(64'h0, 3'd0, 1, 64'h40, 64'h40));
        repeat (2) step(0, 32'h0, 64'h0, 1, 0);

        // Back-pressure: A,B,C with i_ready low for 3 cycles.
        a = rand_inst(); b = rand_inst(); c = rand_inst();
        step(1, a, 64'h1000, 0, 0);
        step(1, b, 64'h1004, 0, 0);
        step(1, c, 64'h1008, 0, 0);
        step(1, c, 64'h1008, 1, 0);
        step(1, c, 64'h1008, 1, 0);
        repeat (3) step(0, 32'h0, 64'h0, 1, 0);

        // Fill to FULL, then flush with a beat presented.
        step(1, rand_inst(), 64'h2000, 0, 0);
        step(1, rand_inst(), 64'h2004, 0, 0);
        step(1, 32'h00100093, 64'h2008, 0, 1);
        repeat (3) step(0, 32'h0, 64'h0, 1, 0);

        // Random traffic with occasional flushes and one mid-run reset.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            step($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end
        repeat (4) step(0, 32'h0, 64'h0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
